// File: rtl/pwm_output_stage_if.sv
// Control-register and pin-drive bundle between the SPI register block,
// the PWM output stage and the output pads.
interface pwm_output_stage_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] pwm_out;
  logic        period_start;

  // Register-block side: owns the control registers, observes the pins.
  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  pwm_out,
    input  period_start
  );

  // Output-stage side: consumes the control registers, drives the pins.
  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output pwm_out,
    output period_start
  );
endinterface

// File: rtl/pwm_output_stage.sv
// PWM output stage: drives 16 user pins either static high or from one shared
// 8-bit PWM waveform. The duty cycle is shadowed and only loaded at the period
// wrap, so every period is glitch-free; enables act immediately.
module pwm_output_stage #(
  parameter int CLK_DIV = 13
) (
  input  logic               clk,
  input  logic               rst,
  pwm_output_stage_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0] CNT_LAST = 8'd254;

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_sh;
  logic [15:0]      pwm_out_p1;
  logic             period_start_p1;
  logic             tick;
  logic             wrap;
  logic             pwm_lvl;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;

  // Full duty is forced high so the 255-step counter never shows a one-step dropout.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == 8'hFF) ? 1'b1 : (cnt < duty);
  endfunction

  assign tick    = (div_cnt == DIV_LAST);
  assign wrap    = tick && (pwm_cnt == CNT_LAST);
  assign pwm_lvl = pwm_level(pwm_cnt, duty_sh);
  assign en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // Prescaler: one counter step every CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // PWM counter: 0..254, so a period is 255 steps and 255 is never reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= (pwm_cnt == CNT_LAST) ? 8'd0 : pwm_cnt + 8'd1;
    end
  end

  // Duty shadow and period marker: loaded together on the wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh         <= '0;
      period_start_p1 <= 1'b0;
    end else begin
      period_start_p1 <= wrap;
      if (wrap) begin
        duty_sh <= bus.pwm_duty_cycle;
      end
    end
  end

  // ---- stage p1: registered pin drive, enables applied unshadowed ----
  // Output register: per pin, disabled -> low, PWM mode -> waveform, else static high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out_p1 <= '0;
    end else begin
      pwm_out_p1 <= en_out & (en_pwm ? {16{pwm_lvl}} & en_pwm | ~en_pwm : 16'hFFFF);
    end
  end

  assign bus.pwm_out      = pwm_out_p1;
  assign bus.period_start = period_start_p1;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with CLK_DIV=4 (period 1020 clk).
module tb_pwm_output_stage;
  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 255 * CLK_DIV;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;
  int   high;
  int   ps_at;

  pwm_output_stage_if bus ();

  pwm_output_stage #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance k rising edges; return 1 time unit after the last one.
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
  endtask

  // Edges until period_start is seen; limit+1 on timeout.
  task automatic wait_ps(input int limit, output int cnt);
    cnt = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (bus.period_start === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  // One full period of samples of pin 0; optional duty write at sample wr_at.
  task automatic measure(input int wr_at, input logic [7:0] wr_val,
                         output int hi, output int ps_pos);
    hi     = 0;
    ps_pos = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      step(1);
      if (bus.pwm_out[0] === 1'b1) hi++;
      if (bus.period_start === 1'b1 && ps_pos == 0) ps_pos = i;
      if (i == wr_at) bus.pwm_duty_cycle = wr_val;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_en(16'h0000, 16'h0000);
    bus.pwm_duty_cycle = 8'h00;

    // Reset state and static-high latency
    step(1);
    check("reset_pwm_out", bus.pwm_out, 16'h0000);
    check("reset_period_start", bus.period_start, 1'b0);
    rst = 1'b0;
    set_en(16'hFFFF, 16'h0000);
    step(1);
    check("static_all_high", bus.pwm_out, 16'hFFFF);
    rst = 1'b1;
    step(1);
    check("rst_clears_out", bus.pwm_out, 16'h0000);

    // 50% duty on pin 0; first period runs with duty_sh=0
    rst = 1'b0;
    set_en(16'h0001, 16'h0001);
    bus.pwm_duty_cycle = 8'h80;
    step(500);
    check("first_period_low", bus.pwm_out, 16'h0000);
    wait_ps(2000, n);
    check("first_wrap_time", n, PERIOD - 500);
    measure(0, 8'h00, high, ps_at);
    check("duty80_high", high, 512);
    check("duty80_period", ps_at, PERIOD);

    // Extremes: 0x00 then 0xFF (checked from the 2nd wrap)
    bus.pwm_duty_cycle = 8'h00;
    measure(0, 8'h00, high, ps_at);
    check("duty80_high_again", high, 512);
    measure(0, 8'h00, high, ps_at);
    check("duty00_high", high, 0);
    bus.pwm_duty_cycle = 8'hFF;
    measure(0, 8'hFF, high, ps_at);
    measure(0, 8'hFF, high, ps_at);
    check("dutyFF_high_p2", high, PERIOD);
    check("dutyFF_period_p2", ps_at, PERIOD);
    measure(0, 8'hFF, high, ps_at);
    check("dutyFF_high_p3", high, PERIOD);

    // Shadowing: 0x40 active, 0xC0 written mid-period
    bus.pwm_duty_cycle = 8'h40;
    measure(0, 8'h40, high, ps_at);
    check("dutyFF_before_40", high, PERIOD);
    measure(500, 8'hC0, high, ps_at);
    check("duty40_kept", high, 8'h40 * CLK_DIV);
    measure(0, 8'hC0, high, ps_at);
    check("dutyC0_next", high, 8'hC0 * CLK_DIV);

    // Mixed pins
    set_en(16'hF00F, 16'h0F0F);
    bus.pwm_duty_cycle = 8'h20;
    measure(0, 8'h20, high, ps_at);
    check("mixed_wrap_aligned", ps_at, PERIOD);
    step(1);
    check("mixed_pulse_high", bus.pwm_out, 16'hF00F);
    step(39);
    set_en(16'hF00E, 16'h0F0F);
    step(1);
    check("pin0_cut_mid_pulse", bus.pwm_out, 16'hF00E);
    set_en(16'hF00F, 16'h0F0F);
    step(159);
    check("mixed_pulse_low", bus.pwm_out, 16'hF000);

    // Mid-period reset at pwm_cnt=100 (state after edge W+400)
    step(200);
    set_en(16'hFFFF, 16'hFFFF);
    bus.pwm_duty_cycle = 8'hFF;
    rst = 1'b1;
    step(1);
    check("midrst_pwm_out", bus.pwm_out, 16'h0000);
    check("midrst_period_start", bus.period_start, 1'b0);
    rst = 1'b0;
    step(10);
    check("midrst_first_period_low", bus.pwm_out, 16'h0000);
    wait_ps(2000, n);
    check("midrst_wrap_time", n, PERIOD - 10);
    step(1);
    check("midrst_after_wrap", bus.pwm_out, 16'hFFFF);
    check("period_start_one_clk", bus.period_start, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
